reorder_buffer: RTL and testbench

In-order retirement buffer of the Tomasulo RISC-V core, directly upstream of the register file. It allocates a tag per issued instruction and captures results from the common data bus (CDB). It retires one entry per cycle from the head, driving the register-file commit port and the store-commit signal, and flushes the machine on a branch mispredict. Tag 0 is reserved as "no dependency", so the buffer never hands it out.

---
 rtl/reorder_buffer_pkg.sv | 32 +++
 rtl/reorder_buffer.sv | 166 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared types, sizes and tag arithmetic for the reorder buffer
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;

  typedef logic [3:0]  rob_index_t;
  typedef logic [4:0]  reg_index_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic       busy;
    logic       ready;
    rob_type_e  rtype;
    reg_index_t rd;
    data_t      val;
    logic       pred_jump;
    logic       jump;
    data_t      target;
  } rob_entry_t;

  // Tag 0 means "no dependency", so pointers wrap from the last tag back to 1.
  function automatic rob_index_t rob_inc(input rob_index_t idx);
    return (idx == rob_index_t'(ROB_SIZE - 1)) ? rob_index_t'(1) : idx + rob_index_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer: tag allocation, CDB capture, commit and mispredict flush
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter bit ISSUE_FULL_CHECK = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,

  input  logic        issue_ready,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_type,
  input  logic        issue_pred_jump,
  output logic [3:0]  rob_next_index,
  output logic        rob_full,

  input  logic        cdb_valid,
  input  logic [3:0]  cdb_rob_index,
  input  logic [31:0] cdb_val,
  input  logic        cdb_jump,
  input  logic [31:0] cdb_target,

  input  logic [3:0]  dc_rs1_depend,
  input  logic [3:0]  dc_rs2_depend,
  output logic        rob_rs1_ready,
  output logic        rob_rs2_ready,
  output logic [31:0] rob_rs1_val,
  output logic [31:0] rob_rs2_val,

  output logic        rob_to_reg_commit,
  output logic [3:0]  rob_to_reg_rob_index,
  output logic [4:0]  rob_to_reg_index,
  output logic [31:0] rob_to_reg_val,

  output logic        rob_to_lsb_commit,
  output logic [3:0]  rob_to_lsb_rob_index,

  output logic        rob_flush,
  output logic [31:0] rob_flush_pc
);

  rob_entry_t entries [ROB_SIZE];
  rob_index_t head;
  rob_index_t tail;
  logic [3:0] count;

  rob_entry_t head_entry;
  logic       retire;
  logic       mispredict;
  logic       issue_fire;

  assign rob_next_index = tail;
  assign rob_full       = (count == 4'(ROB_SIZE - 1));

  assign head_entry = entries[head];
  assign retire     = head_entry.busy && head_entry.ready;
  assign mispredict = retire && (head_entry.rtype == ROB_BRANCH)
                      && (head_entry.jump != head_entry.pred_jump);
  // A mispredicting retire squashes everything younger, including this cycle's issue.
  assign issue_fire = issue_ready && !rob_full && !mispredict;

  // Operand lookup; a same-cycle CDB broadcast to the queried tag is bypassed.
  function automatic logic [32:0] forward(input rob_index_t tag);
    logic [32:0] res;
    res = '0;
    if (tag != '0 && entries[tag].busy) begin
      if (cdb_valid && cdb_rob_index == tag)
        res = {1'b1, cdb_val};
      else if (entries[tag].ready)
        res = {1'b1, entries[tag].val};
    end
    return res;
  endfunction

  always_comb begin
    rob_rs1_ready = 1'b0;
    rob_rs1_val   = '0;
    rob_rs2_ready = 1'b0;
    rob_rs2_val   = '0;
    {rob_rs1_ready, rob_rs1_val} = forward(dc_rs1_depend);
    {rob_rs2_ready, rob_rs2_val} = forward(dc_rs2_depend);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head                 <= rob_index_t'(1);
      tail                 <= rob_index_t'(1);
      count                <= '0;
      rob_to_reg_commit    <= 1'b0;
      rob_to_reg_rob_index <= '0;
      rob_to_reg_index     <= '0;
      rob_to_reg_val       <= '0;
      rob_to_lsb_commit    <= 1'b0;
      rob_to_lsb_rob_index <= '0;
      rob_flush            <= 1'b0;
      rob_flush_pc         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i].busy  <= 1'b0;
        entries[i].ready <= 1'b0;
      end
    end else if (rdy_in) begin
      rob_to_reg_commit <= 1'b0;
      rob_to_lsb_commit <= 1'b0;
      rob_flush         <= 1'b0;

      if (cdb_valid && entries[cdb_rob_index].busy) begin
        entries[cdb_rob_index].ready  <= 1'b1;
        entries[cdb_rob_index].val    <= cdb_val;
        entries[cdb_rob_index].jump   <= cdb_jump;
        entries[cdb_rob_index].target <= cdb_target;
      end

      if (issue_fire) begin
        entries[tail] <= '{busy:      1'b1,
                           ready:     1'b0,
                           rtype:     rob_type_e'(issue_type),
                           rd:        issue_rd,
                           val:       '0,
                           pred_jump: issue_pred_jump,
                           jump:      1'b0,
                           target:    '0};
        tail <= rob_inc(tail);
      end

      if (retire) begin
        entries[head].busy <= 1'b0;
        head               <= rob_inc(head);
        case (head_entry.rtype)
          ROB_REG, ROB_BRANCH: begin
            rob_to_reg_commit    <= 1'b1;
            rob_to_reg_rob_index <= head;
            rob_to_reg_index     <= head_entry.rd;
            rob_to_reg_val       <= head_entry.val;
          end
          ROB_STORE: begin
            rob_to_lsb_commit    <= 1'b1;
            rob_to_lsb_rob_index <= head;
          end
          default: ;
        endcase
      end

      case ({issue_fire, retire})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: ;
      endcase

      if (mispredict) begin
        rob_flush    <= 1'b1;
        rob_flush_pc <= head_entry.target;
        head         <= rob_index_t'(1);
        tail         <= rob_index_t'(1);
        count        <= '0;
        for (int i = 0; i < ROB_SIZE; i++)
          entries[i].busy <= 1'b0;
      end
    end
  end

  // Upstream must honour rob_full.
  issue_while_full: assert property (@(posedge clk_in)
    disable iff (rst_in || !ISSUE_FULL_CHECK) !(rdy_in && issue_ready && rob_full));

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer commit order, flush, forwarding and stalls
module tb_reorder_buffer;

  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2;
  localparam logic [2:0] K_REG = 3'b001, K_STORE = 3'b010, K_FLUSH = 3'b101;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_ready, issue_pred_jump;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_type;
  logic [3:0]  rob_next_index;
  logic        rob_full;
  logic        cdb_valid, cdb_jump;
  logic [3:0]  cdb_rob_index;
  logic [31:0] cdb_val, cdb_target;
  logic [3:0]  dc_rs1_depend, dc_rs2_depend;
  logic        rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_val, rob_rs2_val;
  logic        rob_to_reg_commit;
  logic [3:0]  rob_to_reg_rob_index;
  logic [4:0]  rob_to_reg_index;
  logic [31:0] rob_to_reg_val;
  logic        rob_to_lsb_commit;
  logic [3:0]  rob_to_lsb_rob_index;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  reorder_buffer #(.ISSUE_FULL_CHECK(1'b0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_ready(issue_ready), .issue_rd(issue_rd), .issue_type(issue_type),
    .issue_pred_jump(issue_pred_jump),
    .rob_next_index(rob_next_index), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_target(cdb_target),
    .dc_rs1_depend(dc_rs1_depend), .dc_rs2_depend(dc_rs2_depend),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
    .rob_to_reg_commit(rob_to_reg_commit), .rob_to_reg_rob_index(rob_to_reg_rob_index),
    .rob_to_reg_index(rob_to_reg_index), .rob_to_reg_val(rob_to_reg_val),
    .rob_to_lsb_commit(rob_to_lsb_commit), .rob_to_lsb_rob_index(rob_to_lsb_rob_index),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic rdy_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [3:0] t, input logic [4:0] rd,
                      input logic [31:0] v, input logic [31:0] pc);
    exp_t e;
    e.kind = k; e.tag = t; e.rd = rd; e.val = v; e.pc = pc;
    sb.push_back(e);
  endtask

  // Commit outputs only change on an enabled edge, so only those edges carry a fresh pulse.
  always @(posedge clk_in) rdy_q = rdy_in;

  always @(negedge clk_in) begin
    if (rdy_q && (rob_to_reg_commit || rob_to_lsb_commit || rob_flush)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: actual reg=%0b lsb=%0b flush=%0b tag=%0d required none",
                 rob_to_reg_commit, rob_to_lsb_commit, rob_flush, rob_to_reg_rob_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_kind", {29'd0, rob_flush, rob_to_lsb_commit, rob_to_reg_commit}, {29'd0, e.kind});
        if (e.kind[0]) begin
          check("reg_tag", {28'd0, rob_to_reg_rob_index}, {28'd0, e.tag});
          check("reg_rd", {27'd0, rob_to_reg_index}, {27'd0, e.rd});
          check("reg_val", rob_to_reg_val, e.val);
        end
        if (e.kind[1]) check("lsb_tag", {28'd0, rob_to_lsb_rob_index}, {28'd0, e.tag});
        if (e.kind[2]) check("flush_pc", rob_flush_pc, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] ty, input logic pj);
    issue_ready = 1'b1; issue_rd = rd; issue_type = ty; issue_pred_jump = pj;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] v, input logic j, input logic [31:0] t);
    cdb_valid = 1'b1; cdb_rob_index = tag; cdb_val = v; cdb_jump = j; cdb_target = t;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_ready = 1'b0; issue_rd = '0; issue_type = T_REG; issue_pred_jump = 1'b0;
    cdb_valid = 1'b0; cdb_rob_index = '0; cdb_val = '0; cdb_jump = 1'b0; cdb_target = '0;
    dc_rs1_depend = '0; dc_rs2_depend = '0;
    tick(); tick();
    rst_in = 1'b0;

    check("reset_next_index", {28'd0, rob_next_index}, 32'd1);
    check("reset_full", {31'd0, rob_full}, 32'd0);
    check("reset_outputs", {29'd0, rob_to_reg_commit, rob_to_lsb_commit, rob_flush}, 32'd0);
    check("reset_fwd", {30'd0, rob_rs1_ready, rob_rs2_ready}, 32'd0);

    // Single register result
    push(K_REG, 4'd1, 5'd5, 32'h1234, 32'd0);
    issue(5'd5, T_REG, 1'b0);
    cdb(4'd1, 32'h1234, 1'b0, 32'd0);
    tick();
    tick();
    check("commit_deassert", {31'd0, rob_to_reg_commit}, 32'd0);

    // Out-of-order completion, in-order retirement (tag 2 is a store)
    do_reset();
    push(K_REG, 4'd1, 5'd1, 32'h11, 32'd0);
    push(K_STORE, 4'd2, 5'd0, 32'd0, 32'd0);
    push(K_REG, 4'd3, 5'd3, 32'h33, 32'd0);
    issue(5'd1, T_REG, 1'b0);
    check("next_index_2", {28'd0, rob_next_index}, 32'd2);
    issue(5'd0, T_STORE, 1'b0);
    issue(5'd3, T_REG, 1'b0);
    cdb(4'd3, 32'h33, 1'b0, 32'd0);
    cdb(4'd2, 32'h22, 1'b0, 32'd0);
    cdb(4'd1, 32'h11, 1'b0, 32'd0);
    repeat (4) tick();

    // Fill to capacity, overflow attempt, wrap to tag 1
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      check("fill_next_index", {28'd0, rob_next_index}, i);
      issue(5'(i), T_REG, 1'b0);
    end
    check("full_after_15", {31'd0, rob_full}, 32'd1);
    issue(5'd30, T_REG, 1'b0);
    check("full_after_overflow", {31'd0, rob_full}, 32'd1);
    check("overflow_next_index", {28'd0, rob_next_index}, 32'd1);
    push(K_REG, 4'd1, 5'd1, 32'hA1, 32'd0);
    push(K_REG, 4'd2, 5'd2, 32'hA2, 32'd0);
    cdb(4'd1, 32'hA1, 1'b0, 32'd0);
    cdb(4'd2, 32'hA2, 1'b0, 32'd0);
    check("full_drops", {31'd0, rob_full}, 32'd0);
    check("wrap_next_index", {28'd0, rob_next_index}, 32'd1);
    issue(5'd20, T_REG, 1'b0);
    check("issue_commit_next", {28'd0, rob_next_index}, 32'd2);
    check("issue_commit_full", {31'd0, rob_full}, 32'd0);
    issue(5'd21, T_REG, 1'b0);
    check("refull", {31'd0, rob_full}, 32'd1);
    check("refull_next_index", {28'd0, rob_next_index}, 32'd3);

    // Mispredicted branch squashes younger entries and a same-cycle issue
    do_reset();
    push(K_FLUSH, 4'd1, 5'd1, 32'h104, 32'h100);
    issue(5'd1, T_BRANCH, 1'b0);
    issue(5'd6, T_REG, 1'b0);
    issue(5'd7, T_REG, 1'b0);
    issue(5'd8, T_REG, 1'b0);
    cdb(4'd2, 32'h22, 1'b0, 32'd0);
    cdb(4'd1, 32'h104, 1'b1, 32'h100);
    issue(5'd9, T_REG, 1'b0);
    check("flush_next_index", {28'd0, rob_next_index}, 32'd1);
    check("flush_full", {31'd0, rob_full}, 32'd0);
    dc_rs1_depend = 4'd2;
    #1;
    check("flush_cleared_busy", {31'd0, rob_rs1_ready}, 32'd0);
    dc_rs1_depend = 4'd0;
    cdb(4'd3, 32'h33, 1'b0, 32'd0);
    repeat (2) tick();
    push(K_REG, 4'd1, 5'd10, 32'h55, 32'd0);
    issue(5'd10, T_REG, 1'b0);
    cdb(4'd1, 32'h55, 1'b0, 32'd0);
    repeat (2) tick();

    // Operand forwarding
    do_reset();
    issue(5'd3, T_REG, 1'b0);
    issue(5'd4, T_REG, 1'b0);
    dc_rs1_depend = 4'd2;
    cdb_valid = 1'b1; cdb_rob_index = 4'd2; cdb_val = 32'd7; cdb_jump = 1'b0; cdb_target = '0;
    #1;
    check("fwd_bypass_ready", {31'd0, rob_rs1_ready}, 32'd1);
    check("fwd_bypass_val", rob_rs1_val, 32'd7);
    tick();
    cdb_valid = 1'b0;
    dc_rs2_depend = 4'd1;
    #1;
    check("fwd_entry_ready", {31'd0, rob_rs1_ready}, 32'd1);
    check("fwd_entry_val", rob_rs1_val, 32'd7);
    check("fwd_not_ready", {31'd0, rob_rs2_ready}, 32'd0);
    dc_rs1_depend = 4'd0;
    push(K_REG, 4'd1, 5'd3, 32'd9, 32'd0);
    push(K_REG, 4'd2, 5'd4, 32'd7, 32'd0);
    cdb_valid = 1'b1; cdb_rob_index = 4'd1; cdb_val = 32'd9;
    #1;
    check("fwd_tag0", {31'd0, rob_rs1_ready}, 32'd0);
    check("fwd_rs2_bypass", {31'd0, rob_rs2_ready}, 32'd1);
    check("fwd_rs2_val", rob_rs2_val, 32'd9);
    tick();
    cdb_valid = 1'b0;
    dc_rs2_depend = 4'd0;
    repeat (3) tick();

    // Reset discards pending entries, even with rdy_in low
    do_reset();
    for (int i = 0; i < 4; i++) issue(5'(i + 12), T_REG, 1'b0);
    cdb(4'd2, 32'h2, 1'b0, 32'd0);
    cdb(4'd3, 32'h3, 1'b0, 32'd0);
    rdy_in = 1'b0;
    do_reset();
    rdy_in = 1'b1;
    check("rst_next_index", {28'd0, rob_next_index}, 32'd1);
    cdb(4'd2, 32'h2, 1'b0, 32'd0);
    repeat (3) tick();

    // rdy_in low freezes a ready head
    push(K_REG, 4'd1, 5'd11, 32'h77, 32'd0);
    issue(5'd11, T_REG, 1'b0);
    cdb(4'd1, 32'h77, 1'b0, 32'd0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_commit", {31'd0, rob_to_reg_commit}, 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check("stall_release_commit", {31'd0, rob_to_reg_commit}, 32'd1);
    repeat (3) tick();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
